adder_12: RTL and testbench



---
 rtl/adder_pkg.sv | 8 +
 rtl/full_adder.sv | 17 +
 rtl/adder_12.sv | 49 ++++
 tb/tb_adder_12.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared width and types for the 12-bit registered adder.
package adder_pkg;

  localparam int ADDER_WIDTH = 12;

  typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational link of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  // Propagate term is shared by the sum and the carry.
  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/adder_12.sv
// 12-bit ripple-carry adder with carry-in/carry-out and a registered result.
// {cout, s} = a + b + cin (mod 2^13), one clock of latency, full throughput.
module adder_12
  import adder_pkg::*;
#(
  parameter int N = ADDER_WIDTH
) (
  input  logic  clk,
  input  logic  rst_n,
  input  word_t a,
  input  word_t b,
  input  logic  cin,
  output word_t s,
  output logic  cout
);

  logic [N:0]   w_c;
  logic [N-1:0] w_s;
  logic [N-1:0] r_s;
  logic         r_cout;

  assign w_c[0] = cin;

  // Ripple chain: carry out of cell g feeds cell g+1.
  for (genvar g = 0; g < N; g++) begin : g_fa
    full_adder u_fa (
      .a    (a[g]),
      .b    (b[g]),
      .cin  (w_c[g]),
      .s    (w_s[g]),
      .cout (w_c[g+1])
    );
  end

  // Result register; reset clears it immediately and drops any in-flight sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_s;
      r_cout <= w_c[N];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_adder_12.sv
// Self-checking bench for adder_12: directed boundary cases plus a random run
// against a plain 13-bit arithmetic model.
module tb_adder_12;

  logic        clk;
  logic        rst_n;
  logic [11:0] a, b;
  logic        cin;
  logic [11:0] s;
  logic        cout;

  int n_checks;
  int n_fail;

  adder_12 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 13-bit sum of the operands.
  function automatic logic [12:0] ref_sum(input logic [11:0] x, input logic [11:0] y,
                                          input logic ci);
    logic [12:0] r;
    r = {1'b0, x} + {1'b0, y} + {12'd0, ci};
    return r;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 12'hFFF; b = 12'hFFF; cin = 1'b1;
    #1;
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL reset_initial: got cout=%b s=%h, want cout=0 s=000", cout, s);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({cout, s} !== 13'h0000) begin
        n_fail++;
        $display("FAIL reset_held_edge%0d: got cout=%b s=%h, want cout=0 s=000", i, cout, s);
      end
    end
    // Release mid-cycle, let a nonzero result land, then assert between edges.
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if ({cout, s} !== 13'h1FFF) begin
      n_fail++;
      $display("FAIL reset_release: got cout=%b s=%h, want cout=1 s=FFF", cout, s);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL reset_async: got cout=%b s=%h, want cout=0 s=000", cout, s);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    logic [12:0] exp_v [2];
    logic [11:0] ta [2];
    logic [11:0] tb [2];
    logic        tc [2];
    ta = '{12'hFFF, 12'hFFF}; tb = '{12'h000, 12'h000}; tc = '{1'b1, 1'b0};
    exp_v = '{13'h1000, 13'h0FFF};
    for (int i = 0; i < 2; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i];
      step();
      n_checks++;
      if ({cout, s} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL carry_chain%0d: got %h, want %h", i, {cout, s}, exp_v[i]);
      end
    end
  endtask

  task automatic test_saturate();
    a = 12'hFFF; b = 12'hFFF; cin = 1'b1;
    step();
    n_checks++;
    if ({cout, s} !== 13'h1FFF) begin
      n_fail++;
      $display("FAIL saturate_all_ones: got %h, want 1FFF", {cout, s});
    end
    a = 12'h800; b = 12'h800; cin = 1'b0;
    step();
    n_checks++;
    if ({cout, s} !== 13'h1000) begin
      n_fail++;
      $display("FAIL saturate_msb: got %h, want 1000", {cout, s});
    end
    a = 12'h000; b = 12'h000; cin = 1'b0;
    step();
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL zero_sum: got %h, want 0000", {cout, s});
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ta [3];
    logic [11:0] tb [3];
    logic        tc [3];
    logic [12:0] exp_v [3];
    ta = '{12'h123, 12'h0AB, 12'h7FF};
    tb = '{12'h456, 12'hF00, 12'h001};
    tc = '{1'b0, 1'b1, 1'b0};
    exp_v = '{13'h0579, 13'h0FAC, 13'h0800};
    // Output must still show the previous result before the first edge.
    a = ta[0]; b = tb[0]; cin = tc[0];
    #2;
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL pipe_no_comb_path: got %h, want 0000", {cout, s});
    end
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; cin = tc[i];
      step();
      n_checks++;
      if ({cout, s} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL pipe%0d: got %h, want %h", i, {cout, s}, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    a = 12'h123; b = 12'h456; cin = 1'b0;
    step();
    a = 12'h0AB; b = 12'hF00; cin = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL midreset_clear: got %h, want 0000", {cout, s});
    end
    step();
    n_checks++;
    if ({cout, s} !== 13'h0000) begin
      n_fail++;
      $display("FAIL midreset_held: got %h, want 0000", {cout, s});
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if ({cout, s} !== 13'h0FAC) begin
      n_fail++;
      $display("FAIL midreset_resume: got %h, want 0FAC", {cout, s});
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_v;
    int          errs;
    errs = 0;
    for (int i = 0; i < 1024; i++) begin
      a   = 12'($urandom);
      b   = 12'($urandom);
      cin = 1'($urandom);
      exp_v = ref_sum(a, b, cin);
      step();
      n_checks++;
      if ({cout, s} !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random%0d: got %h, want %h", i, {cout, s}, exp_v);
      end
    end
    $display("random regression: %0d errors in 1024 vectors", errs);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_carry_chain();
    test_saturate();
    test_back_to_back();
    test_reset_mid_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
